ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the 256x16 single-port synchronous RAM (the existing ram module, 1-cycle registered read latency).
- Requester A is the datapath (CPU load/store); requester B is the loader/display port.
- Serialises both requesters onto the single RAM port and returns read data with a valid strobe.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- a_req  in  1  requester A access request; held with a_we/a_addr/a_din stable until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  requester A address.
- a_din  in  DATA_W  requester A write data.
- a_ack  out  1  one-cycle pulse: A's command issued to RAM.
- a_rvalid  out  1  one-cycle pulse: a_dout holds A's read data.
- a_dout  out  DATA_W  A read data, held until A's next read completes.
- b_req, b_we, b_addr, b_din, b_ack, b_rvalid, b_dout: same as A, for requester B.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_dout  in  DATA_W  from RAM dout.

Behaviour:
- Reset: while reset_n=0 at a rising edge, state<=ARB, all acks, rvalids and ram_we<=0, ram_addr/ram_din/a_dout/b_dout<=0, last_grant<=B (so A wins the first tie).
- FSM, 3 states, all outputs registered:
  - ARB: sample a_req/b_req. If none, stay in ARB. Otherwise pick a winner, load ram_addr/ram_din/ram_we from the winner, pulse the winner's ack, update last_grant, and go to ISSUE.
  - ISSUE: command is stable on the RAM port; RAM samples it at the closing edge. ram_we<=0 at that edge. Go to CAPTURE.
  - CAPTURE: ram_dout is valid. For a read, load the winner's dout from ram_dout and pulse its rvalid in the next cycle. Go to ARB.
- Timing, with request sampled at edge E0:
  - ack high in cycle E0..E1.
  - RAM write or read performed at E1.
  - rvalid and dout updated at E2.
  - Next arbitration at E3.
  - One access per 3 cycles; a_ack to a_rvalid = 2 cycles.
- Writes: no rvalid; dout unchanged.
- Arbitration:
  - Single requester is always granted.
  - Both requesting: grant the one that is not last_grant (strict alternation).
  - Requests are only sampled in ARB, so a requester that drops req on seeing ack is never double-granted.
- The losing requester keeps req asserted and is granted at the next ARB (worst-case wait 3 cycles, no starvation).
- ram_addr and ram_din hold their last value outside ISSUE; ram_we is 1 only during ISSUE of a write.
- Reset mid-operation:
  - A command already on the RAM port when reset asserts at its closing edge still completes in RAM.
  - Any rvalid for it is suppressed.
  - No ack is generated after reset until the next ARB.
- Address wrap is not applicable: the full 8-bit space is valid, 0xFF is a legal address.
- A requester that changes its fields before ack gets undefined results; the bench flags this.

Decomposition:
- Package ram_arb_pkg: ADDR_W/DATA_W defaults; state encodings ARB=2'b00, ISSUE=2'b01, CAPTURE=2'b10; grant IDs GNT_A=1'b0, GNT_B=1'b1.
- Optional sub-module rr_pick2: combinational 2-way round-robin picker (inputs req[1:0], last; output winner, any).
- The ram instance stays outside, at the top level.

Test Plan:
- Reset, then A writes 0x00A5 to 0x10: a_ack at cycle 1, ram_we=1 with addr 0x10 in cycle 1 only, no a_rvalid.
- A then reads 0x10: a_rvalid exactly 2 cycles after a_ack with a_dout=0x00A5; b_* outputs unchanged.
- A and B both request from reset (A reads 0x10, B writes 0x1234 to 0xFF):
  - A granted first, B 3 cycles later.
  - A subsequent read of 0xFF by B returns 0x1234.
- A and B hold req continuously for 6 grants: acks alternate A,B,A,B,A,B, spaced 3 cycles apart.
- reset_n=0 for one edge during CAPTURE of a B read:
  - b_rvalid never pulses, all outputs go to 0, FSM in ARB.
  - A pending a_req is then granted first.
- B alone reads 0x00 then 0xFF back-to-back: both complete with correct data, b_ack 3 cycles apart, ram_we=0 throughout.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter:
// default widths, FSM state codes and grant IDs.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] ARB     = 2'b00;
  localparam logic [1:0] ISSUE   = 2'b01;
  localparam logic [1:0] CAPTURE = 2'b10;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker.
// req[0]=A, req[1]=B; last = previous winner; winner/any out.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    winner = GNT_A;
    if (&req) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = GNT_B;
    end
  end

  assign any = |req;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer for one single-port sync RAM.
// Ports: a_*/b_* requesters, ram_* to the external RAM.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_dout,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0] state;
  logic       last_grant;
  logic       cur;
  logic       cur_we;
  logic       winner;
  logic       any;

  rr_pick2 u_pick (
    .req    ({b_req, a_req}),
    .last   (last_grant),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ARB;
      last_grant <= GNT_B;
      cur        <= GNT_A;
      cur_we     <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_dout     <= '0;
      b_dout     <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      unique case (state)
        ARB: begin
          if (any) begin
            if (winner == GNT_B) begin
              ram_we   <= b_we;
              ram_addr <= b_addr;
              ram_din  <= b_din;
              cur_we   <= b_we;
              b_ack    <= 1'b1;
            end else begin
              ram_we   <= a_we;
              ram_addr <= a_addr;
              ram_din  <= a_din;
              cur_we   <= a_we;
              a_ack    <= 1'b1;
            end
            cur        <= winner;
            last_grant <= winner;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          // ram_dout now holds the word read at the ISSUE edge
          if (!cur_we) begin
            if (cur == GNT_B) begin
              b_dout   <= ram_dout;
              b_rvalid <= 1'b1;
            end else begin
              a_dout   <= ram_dout;
              a_rvalid <= 1'b1;
            end
          end
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural
// 256x16 sync RAM and a scoreboard-style reference model.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_din = '0;
  logic          a_ack, a_rvalid;
  logic [DW-1:0] a_dout;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_din = '0;
  logic          b_ack, b_rvalid;
  logic [DW-1:0] b_dout;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_din    (a_din),
    .a_ack    (a_ack),
    .a_rvalid (a_rvalid),
    .a_dout   (a_dout),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_din    (b_din),
    .b_ack    (b_ack),
    .b_rvalid (b_rvalid),
    .b_dout   (b_dout),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // external single-port RAM, 1-cycle registered read
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    apply_reset();
    flags = {a_ack, b_ack, a_rvalid, b_rvalid, ram_we, 1'b0};
    checks++;
    if (flags !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", flags);
    end
    checks++;
    if (ram_addr !== 8'h00 || ram_din !== 16'h0) begin
      errors++;
      $display("FAIL reset_ram got %h/%h want 00/0000",
               ram_addr, ram_din);
    end
    checks++;
    if (a_dout !== 16'h0 || b_dout !== 16'h0) begin
      errors++;
      $display("FAIL reset_dout got %h/%h want 0/0",
               a_dout, b_dout);
    end
  endtask

  task automatic test_write_a();
    reset_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1;
    a_addr = 8'h10; a_din = 16'h00A5;
    step();
    checks++;
    if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack got a=%b b=%b want 1/0", a_ack, b_ack);
    end
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h10 ||
        ram_din !== 16'h00A5) begin
      errors++;
      $display("FAIL wr_port got %b %h %h want 1 10 00a5",
               ram_we, ram_addr, ram_din);
    end
    a_req = 1'b0;
    step();
    checks++;
    if (ram_we !== 1'b0 || a_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse got we=%b ack=%b want 0/0",
               ram_we, a_ack);
    end
    step();
    checks++;
    if (a_rvalid !== 1'b0 || a_dout !== 16'h0) begin
      errors++;
      $display("FAIL wr_norv got rv=%b dout=%h want 0/0000",
               a_rvalid, a_dout);
    end
  endtask

  task automatic test_read_a();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    step();
    checks++;
    if (a_ack !== 1'b1 || ram_we !== 1'b0 ||
        ram_addr !== 8'h10) begin
      errors++;
      $display("FAIL rd_ack got ack=%b we=%b addr=%h want 1 0 10",
               a_ack, ram_we, ram_addr);
    end
    a_req = 1'b0;
    step();
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_early got %b want 0", a_rvalid);
    end
    step();
    checks++;
    if (a_rvalid !== 1'b1 || a_dout !== 16'h00A5) begin
      errors++;
      $display("FAIL rd_data got rv=%b dout=%h want 1/00a5",
               a_rvalid, a_dout);
    end
    checks++;
    if (b_rvalid !== 1'b0 || b_dout !== 16'h0 || b_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_b_quiet got rv=%b dout=%h ack=%b want 0",
               b_rvalid, b_dout, b_ack);
    end
    step();
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse got %b want 0", a_rvalid);
    end
  endtask

  task automatic test_both_from_reset();
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_din = 16'h1234;
    step();
    checks++;
    if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
      errors++;
      $display("FAIL both_first got a=%b b=%b want 1/0", a_ack, b_ack);
    end
    a_req = 1'b0;
    step();
    step();
    checks++;
    if (a_rvalid !== 1'b1 || a_dout !== 16'h00A5 || b_ack !== 1'b0) begin
      errors++;
      $display("FAIL both_ard got rv=%b d=%hback=%b want 1 00a5 0",
               a_rvalid, a_dout, b_ack);
    end
    step();
    checks++;
    if (b_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'hFF) begin
      errors++;
      $display("FAIL both_second got ack=%b we=%b addr=%h want 1 1 ff",
               b_ack, ram_we, ram_addr);
    end
    b_we = 1'b0;
    step();
    step();
    step();
    checks++;
    if (b_ack !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL both_brd_ack got ack=%b we=%b want 1/0",
               b_ack, ram_we);
    end
    b_req = 1'b0;
    step();
    step();
    checks++;
    if (b_rvalid !== 1'b1 || b_dout !== 16'h1234) begin
      errors++;
      $display("FAIL both_brd got rv=%b d=%h want 1/1234",
               b_rvalid, b_dout);
    end
  endtask

  task automatic test_alternate();
    int n = 0;
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'hFF;
    for (int c = 1; c <= 20; c++) begin
      step();
      if ((a_ack || b_ack) && n < 6) begin
        checks++;
        if (b_ack !== n[0] || a_ack !== !n[0] || c != 1 + 3 * n) begin
          errors++;
          $display("FAIL alt_%0d got a=%b b=%b cyc=%0d want b=%b cyc=%0d",
                   n, a_ack, b_ack, c, n[0], 1 + 3 * n);
        end
        n++;
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL alt_count got %0d want 6", n);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    logic [4:0] f;
    apply_reset();
    reset_n = 1'b1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'hFF;
    step();
    checks++;
    if (b_ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_back got %b want 1", b_ack);
    end
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    step();
    reset_n = 1'b0;
    step();
    f = {a_ack, b_ack, a_rvalid, b_rvalid, ram_we};
    checks++;
    if (f !== 5'b0 || ram_addr !== 8'h0 || ram_din !== 16'h0 ||
        a_dout !== 16'h0 || b_dout !== 16'h0) begin
      errors++;
      $display("FAIL mid_clear got f=%b %h %h %h %h want 0",
               f, ram_addr, ram_din, a_dout, b_dout);
    end
    reset_n = 1'b1;
    b_req = 1'b1;
    step();
    checks++;
    if (a_ack !== 1'b1 || b_ack !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_regrant got a=%b b=%b brv=%b want 1 0 0",
               a_ack, b_ack, b_rvalid);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h00; a_din = 16'h5A5A;
    step();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h00;
    step();
    step();
    for (int c = 4; c <= 9; c++) begin
      step();
      checks++;
      if (ram_we !== 1'b0) begin
        errors++;
        $display("FAIL b2b_we_%0d got %b want 0", c, ram_we);
      end
      if (c == 4 || c == 7) begin
        checks++;
        if (b_ack !== 1'b1 ||
            ram_addr !== ((c == 4) ? 8'h00 : 8'hFF)) begin
          errors++;
          $display("FAIL b2b_ack_%0d got ack=%b addr=%h", c,
                   b_ack, ram_addr);
        end
        if (c == 4) b_addr = 8'hFF;
        else b_req = 1'b0;
      end
      if (c == 6 || c == 9) begin
        checks++;
        if (b_rvalid !== 1'b1 ||
            b_dout !== ((c == 6) ? 16'h5A5A : 16'h1234)) begin
          errors++;
          $display("FAIL b2b_rd_%0d got rv=%b d=%h", c,
                   b_rvalid, b_dout);
        end
      end
    end
  endtask

  task automatic test_random();
    op_t           qa[$];
    op_t           qb[$];
    op_t           op;
    logic [AW-1:0] pool [4];
    logic [DW-1:0] ref_mem [256];
    bit            known [256];
    int            exp_a = -1, exp_b = -1;
    logic [DW-1:0] dat_a, dat_b, hold_a, hold_b;
    bit            ok_a, ok_b, hold_ok_a, hold_ok_b;
    logic          pa, pb, w, exp_w;
    logic          prev_w = 1'b1;
    int            last_ack = -1;
    bit            done = 0;
    pool[0] = 8'h00; pool[1] = 8'h7E;
    pool[2] = 8'h80; pool[3] = 8'hFF;
    for (int i = 0; i < 256; i++) known[i] = 0;
    for (int i = 0; i < 10; i++) begin
      op.we = 1'($urandom_range(0, 1));
      op.addr = pool[$urandom_range(0, 3)];
      op.din = 16'($urandom);
      qa.push_back(op);
      op.we = 1'($urandom_range(0, 1));
      op.addr = pool[$urandom_range(0, 3)];
      op.din = 16'($urandom);
      qb.push_back(op);
    end
    dat_a = '0; dat_b = '0; ok_a = 0; ok_b = 0;
    hold_a = '0; hold_b = '0; hold_ok_a = 1; hold_ok_b = 1;
    apply_reset();
    reset_n = 1'b1;
    a_req = 1'b1; a_we = qa[0].we; a_addr = qa[0].addr; a_din = qa[0].din;
    b_req = 1'b1; b_we = qb[0].we; b_addr = qb[0].addr; b_din = qb[0].din;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      step();
      pa = a_req;
      pb = b_req;
      if (a_ack || b_ack) begin
        w = b_ack;
        exp_w = (pa && pb) ? !prev_w : pb;
        checks++;
        if ((a_ack && b_ack) || w !== exp_w ||
            (last_ack >= 0 && cyc - last_ack != 3)) begin
          errors++;
          $display("FAIL rnd_grant cyc=%0d got a=%b b=%b gap=%0d want w=%b gap=3",
                   cyc, a_ack, b_ack, cyc - last_ack, exp_w);
        end
        op = w ? qb.pop_front() : qa.pop_front();
        checks++;
        if (ram_we !== op.we || ram_addr !== op.addr ||
            (op.we && ram_din !== op.din)) begin
          errors++;
          $display("FAIL rnd_port cyc=%0d got %b %h %h want %b %h %h",
                   cyc, ram_we, ram_addr, ram_din, op.we, op.addr, op.din);
        end
        if (op.we) begin
          ref_mem[op.addr] = op.din;
          known[op.addr] = 1;
        end else if (w) begin
          exp_b = cyc + 2; dat_b = ref_mem[op.addr]; ok_b = known[op.addr];
        end else begin
          exp_a = cyc + 2; dat_a = ref_mem[op.addr]; ok_a = known[op.addr];
        end
        prev_w = w;
        last_ack = cyc;
      end else begin
        checks++;
        if (ram_we !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle_we cyc=%0d got %b want 0", cyc, ram_we);
        end
      end
      checks++;
      if (a_rvalid !== (exp_a == cyc) || b_rvalid !== (exp_b == cyc)) begin
        errors++;
        $display("FAIL rnd_rvalid cyc=%0d got %b/%b want %b/%b", cyc,
                 a_rvalid, b_rvalid, exp_a == cyc, exp_b == cyc);
      end
      if (exp_a == cyc) begin hold_a = dat_a; hold_ok_a = ok_a; end
      if (exp_b == cyc) begin hold_b = dat_b; hold_ok_b = ok_b; end
      if (hold_ok_a) begin
        checks++;
        if (a_dout !== hold_a) begin
          errors++;
          $display("FAIL rnd_adout cyc=%0d got %h want %h",
                   cyc, a_dout, hold_a);
        end
      end
      if (hold_ok_b) begin
        checks++;
        if (b_dout !== hold_b) begin
          errors++;
          $display("FAIL rnd_bdout cyc=%0d got %h want %h",
                   cyc, b_dout, hold_b);
        end
      end
      a_req = (qa.size() > 0);
      if (a_req) begin
        a_we = qa[0].we; a_addr = qa[0].addr; a_din = qa[0].din;
      end
      b_req = (qb.size() > 0);
      if (b_req) begin
        b_we = qb[0].we; b_addr = qb[0].addr; b_din = qb[0].din;
      end
      done = (qa.size() == 0) && (qb.size() == 0) &&
             (exp_a <= cyc) && (exp_b <= cyc);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rnd_timeout left a=%0d b=%0d want 0/0",
               qa.size(), qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_a();
    test_both_from_reset();
    test_alternate();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
